// File: rtl/nn_pkg.sv
// Constants and state type shared by the conv layer, the readout block and the top level.
package nn_pkg;

  localparam int FMAP_POS = 36;
  localparam int FMAP_CH  = 2;
  localparam int DATA_W   = 8;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DRAIN   = 2'd1,
    DONE    = 2'd2
  } readout_state_t;

endpackage

// File: rtl/result_regfile.sv
// Feature result buffer: one byte pair written per position, combinational read of any byte.
module result_regfile #(
  parameter  int N_POS = 36,
  parameter  int DW    = 8,
  localparam int PW    = $clog2(N_POS),
  localparam int NB    = N_POS * 2,
  localparam int AW    = $clog2(NB)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [PW-1:0] wr_pos,
  input  logic [DW-1:0] wdata_0,
  input  logic [DW-1:0] wdata_1,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem_flat [NB];

  // Each position owns its byte pair; address 2*pos holds channel 0, 2*pos+1 channel 1.
  for (genvar gi = 0; gi < N_POS; gi++) begin : g_pos
    logic          hit;
    logic [DW-1:0] lo_q, lo_d, hi_q, hi_d;

    assign hit = we && (wr_pos == PW'(gi));

    always_comb begin
      lo_d = lo_q;
      hi_d = hi_q;
      if (hit) begin
        lo_d = wdata_0;
        hi_d = wdata_1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        lo_q <= '0;
        hi_q <= '0;
      end else begin
        lo_q <= lo_d;
        hi_q <= hi_d;
      end
    end

    assign mem_flat[2*gi]   = lo_q;
    assign mem_flat[2*gi+1] = hi_q;
  end

  assign rd_data = (rd_addr < AW'(NB)) ? mem_flat[rd_addr] : '0;

endmodule

// File: rtl/feature_map_readout.sv
// Collects per-position channel pairs into a result buffer, then streams the buffer out
// one byte per valid/ready transfer.
module feature_map_readout
  import nn_pkg::*;
#(
  parameter  int N_POS = FMAP_POS,
  parameter  int N_CH  = FMAP_CH,
  parameter  int DW    = DATA_W,
  localparam int NB    = N_POS * N_CH,
  localparam int IW    = $clog2(NB),
  localparam int PW    = $clog2(N_POS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data_0,
  input  logic [DW-1:0] in_data_1,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic [IW-1:0] out_index,
  output logic          out_last,
  output logic          done,
  output logic          overflow
);

  localparam logic [PW-1:0] LAST_POS = PW'(N_POS - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

  readout_state_t state_q, state_d;
  logic [PW-1:0]  wr_pos_q, wr_pos_d;
  logic [IW-1:0]  rd_ptr_q, rd_ptr_d;
  logic           overflow_q, overflow_d;
  logic           we;
  logic [DW-1:0]  rd_data;

  result_regfile #(
    .N_POS (N_POS),
    .DW    (DW)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (we),
    .wr_pos  (wr_pos_q),
    .wdata_0 (in_data_0),
    .wdata_1 (in_data_1),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

  always_comb begin
    state_d    = state_q;
    wr_pos_d   = wr_pos_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    we         = 1'b0;
    // clear outranks everything, including a coincident sample, which is silently dropped
    if (clear) begin
      state_d    = COLLECT;
      wr_pos_d   = '0;
      rd_ptr_d   = '0;
      overflow_d = 1'b0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (in_valid) begin
            we = 1'b1;
            if (wr_pos_q == LAST_POS) begin
              state_d  = DRAIN;
              rd_ptr_d = '0;
            end else begin
              wr_pos_d = wr_pos_q + PW'(1);
            end
          end
        end
        DRAIN: begin
          if (in_valid) overflow_d = 1'b1;
          if (out_ready) begin
            if (rd_ptr_q == LAST_IDX) state_d = DONE;
            else                      rd_ptr_d = rd_ptr_q + IW'(1);
          end
        end
        DONE: begin
          if (in_valid) overflow_d = 1'b1;
        end
        default: state_d = COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= COLLECT;
      wr_pos_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_pos_q   <= wr_pos_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  assign out_valid = (state_q == DRAIN);
  assign out_data  = out_valid ? rd_data : '0;
  assign out_index = rd_ptr_q;
  assign out_last  = out_valid && (rd_ptr_q == LAST_IDX);
  assign done      = (state_q == DONE);
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_feature_map_readout.sv
// Randomised self-checking bench for feature_map_readout against a byte-array reference model.
module tb_feature_map_readout;

  localparam int NPOS = 36;
  localparam int NB   = 72;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data_0 = '0;
  logic [7:0] in_data_1 = '0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [7:0] out_data;
  logic [6:0] out_index;
  logic       out_last;
  logic       done;
  logic       overflow;

  feature_map_readout dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_data_0 (in_data_0),
    .in_data_1 (in_data_1),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last),
    .done      (done),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Reference: the frame the stream must reproduce, plus the expected sticky overflow.
  logic [7:0] ref_mem [NB];
  logic       exp_ovf;
  int         n_cmp = 0;
  int         n_mis = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag, input logic exp_done);
    check_eq({tag, "_valid"}, out_valid, 0);
    check_eq({tag, "_done"}, done, exp_done);
    check_eq({tag, "_ovf"}, overflow, exp_ovf);
  endtask

  // mode 0: 2p/2p+1, 1: 0x80+p/0xC0+p, 2: random. Random idle gaps between samples.
  task automatic fill(input int npos, input int mode);
    int p = 0;
    while (p < npos) begin
      @(negedge clk);
      check_idle_outputs("fill", 0);
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        case (mode)
          0: begin in_data_0 = 8'(2*p); in_data_1 = 8'(2*p+1); end
          1: begin in_data_0 = 8'(8'h80 + p); in_data_1 = 8'(8'hC0 + p); end
          default: begin in_data_0 = 8'($urandom); in_data_1 = 8'($urandom); end
        endcase
        ref_mem[2*p]   = in_data_0;
        ref_mem[2*p+1] = in_data_1;
        p++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    $display("fill %0d positions mode %0d", npos, mode);
    if (npos == NPOS) begin
      check_eq("first_valid", out_valid, 1);
      check_eq("first_index", out_index, 0);
    end
  endtask

  // Drains with random ready; optional overflow pulse at ovf_at, 5-cycle stall at hold_at,
  // and early exit (before transferring) at stop_at.
  task automatic drain(input int ready_pct, input int ovf_at, input int hold_at, input int stop_at);
    int idx = 0;
    int held = 0;
    int cyc = 0;
    bit ovf_done = 0;
    bit rdy;
    while (idx < NB && cyc < 2000) begin
      if (cyc != 0) @(negedge clk);
      cyc++;
      check_eq("valid", out_valid, 1);
      check_eq("index", out_index, idx);
      check_eq("data", out_data, ref_mem[idx]);
      check_eq("last", out_last, idx == NB-1);
      check_eq("done_low", done, 0);
      check_eq("ovf", overflow, exp_ovf);
      if (idx == stop_at) return;
      rdy = ($urandom_range(1, 100) <= ready_pct);
      if (idx == hold_at && held < 5) begin rdy = 0; held++; end
      out_ready = rdy;
      if (idx == ovf_at && !ovf_done) begin
        in_valid = 1'b1; in_data_0 = 8'hAA; in_data_1 = 8'hBB; ovf_done = 1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      if (in_valid) exp_ovf = 1'b1;
      if (rdy) begin
        $display("xfer idx=%0d data=%02h", idx, ref_mem[idx]);
        idx++;
      end
    end
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check_eq("drain_count", idx, NB);
    check_idle_outputs("after_drain", 1);
  endtask

  task automatic pulse_clear(input logic with_valid);
    @(negedge clk);
    clear = 1'b1;
    in_valid = with_valid;
    in_data_0 = 8'h55; in_data_1 = 8'h66;
    @(negedge clk);
    clear = 1'b0;
    in_valid = 1'b0;
    exp_ovf = 1'b0;
    $display("clear with_valid=%0b", with_valid);
    check_idle_outputs("after_clear", 0);
  endtask

  initial begin
    exp_ovf = 1'b0;
    for (int i = 0; i < NB; i++) ref_mem[i] = '0;
    #12;
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_data", out_data, 0);
    check_eq("rst_index", out_index, 0);
    check_eq("rst_last", out_last, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_ovf", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill and full drain at full throughput.
    fill(NPOS, 0);
    drain(100, -1, -1, -1);

    // Backpressure at index 10, random data.
    pulse_clear(0);
    fill(NPOS, 2);
    drain(100, -1, 10, -1);

    // Overflow during drain at index 3.
    pulse_clear(0);
    fill(NPOS, 0);
    drain(100, 3, -1, -1);

    // Clear mid-collect together with in_valid.
    pulse_clear(0);
    fill(10, 2);
    pulse_clear(1);
    fill(NPOS, 1);
    drain(70, -1, -1, -1);

    // Re-arm after DONE: in_valid in DONE sets overflow, clear and refill.
    @(negedge clk);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    exp_ovf = 1'b1;
    check_idle_outputs("done_ovf", 1);
    pulse_clear(0);
    fill(NPOS, 2);
    drain(60, -1, -1, -1);

    // Async reset mid-drain at index 40, with overflow already set.
    pulse_clear(0);
    fill(NPOS, 2);
    drain(80, 3, -1, 40);
    #2;
    rst_n = 1'b0;
    #1;
    exp_ovf = 1'b0;
    $display("async reset mid-drain");
    check_idle_outputs("async_rst", 0);
    for (int i = 0; i < NB; i++) ref_mem[i] = '0;
    @(negedge clk);
    out_ready = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_idle_outputs("post_rst", 0);
    end
    out_ready = 1'b0;
    fill(NPOS, 2);
    drain(50, -1, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/feature_map_readout.md
# feature_map_readout

Collects the per-position conv/ReLU results (one sample per channel per `in_valid` pulse) into an internal result buffer. Once the buffer is full it streams the buffer out one byte per transfer over a valid/ready handshake toward the output pins. It is the reader-side counterpart of the pixel loader: the loader writes 64 input bytes in, this block reads the 72 feature bytes out. It sits between the last compute stage and the `uo_out`/`uio_out` drivers in `tt_um_mark28277`.

## Interface
Parameters:
- `N_POS`, default 36: number of spatial positions collected (6x6 map).
- `N_CH`, default 2: channels per position; fixed at 2 by the port list.
- `DW`, default 8: sample and output byte width.

Ports:
- `clk`: in, 1 bit. Single clock; all state changes on the rising edge.
- `rst_n`: in, 1 bit. Asynchronous, active-low reset.
- `clear`: in, 1 bit. Synchronous restart to COLLECT.
- `in_valid`: in, 1 bit. One position's samples present this cycle.
- `in_data_0`: in, `DW` bits. Channel 0 sample.
- `in_data_1`: in, `DW` bits. Channel 1 sample.
- `out_ready`: in, 1 bit. Consumer accepts the byte this cycle (already synchronised by the top level).
- `out_valid`: out, 1 bit. Byte available.
- `out_data`: out, `DW` bits. Current byte.
- `out_index`: out, `$clog2(N_POS*N_CH)` bits. Index of the current byte, 0..71.
- `out_last`: out, 1 bit. Current byte is index `N_POS*N_CH-1`.
- `done`: out, 1 bit. Full frame drained; held until `clear` or reset.
- `overflow`: out, 1 bit. Sticky; set when a sample is dropped.

## Operation
- Storage is `N_POS*N_CH` bytes. Byte address = `2*pos + ch`, so the layout is position-major, channel-minor.
- States: COLLECT, DRAIN, DONE. Reset state is COLLECT.
- COLLECT:
  - Each `in_valid` writes `in_data_0` to `mem[2*wr_pos]` and `in_data_1` to `mem[2*wr_pos+1]`, then increments `wr_pos`.
  - The write with `wr_pos == N_POS-1` moves the state to DRAIN, with `rd_ptr = 0`.
- DRAIN:
  - `out_valid = 1`, `out_data = mem[rd_ptr]`, `out_index = rd_ptr`.
  - A transfer occurs when `out_valid && out_ready`; `rd_ptr` then increments.
  - The transfer with `out_last = 1` moves the state to DONE.
- DONE: `out_valid = 0`, `done = 1`. Remains here until `clear`.
- `clear` (any state): next state COLLECT, `wr_pos = 0`, `rd_ptr = 0`, `done = 0`, `overflow = 0`. Buffer contents are not cleared; they are overwritten by the next collect.
- `in_valid` in DRAIN or DONE: the sample is discarded, `overflow` is set to 1, and buffer contents are unchanged.
- `clear` together with `in_valid`: `clear` wins, the sample is discarded, and `overflow` is not set.
- No arithmetic on data; bytes pass through unmodified.
- `wr_pos` never exceeds `N_POS-1` and `rd_ptr` never exceeds `N_POS*N_CH-1`; neither pointer wraps.

## Timing
- Reset values:
  - state COLLECT, `wr_pos = 0`, `rd_ptr = 0`, all buffer bytes 0.
  - `out_valid = 0`, `out_data = 0`, `out_index = 0`, `out_last = 0`, `done = 0`, `overflow = 0`.
- Asserting `rst_n` low mid-DRAIN drops `out_valid` immediately (asynchronous); no partial transfer completes.
- Write latency: a sample accepted at edge k is readable at edge k.
- The last collect write at edge k gives `out_valid = 1` with byte 0 during cycle k→k+1.
- `out_data`, `out_index` and `out_last` are combinational from `rd_ptr` and the buffer. They are stable while `out_valid && !out_ready`.
- With `out_ready` held high, throughput is one byte per cycle: 72 cycles from the first `out_valid` to DONE.
- `done` rises on the edge after the last transfer.
- `overflow` rises on the edge that samples the offending `in_valid`.

## Structure
- Shared package `nn_pkg` holds the constants `FMAP_POS = 36`, `FMAP_CH = 2`, `DATA_W = 8` and the state enum `readout_state_t` (COLLECT, DRAIN, DONE). The conv layer and top level use the same constants.
- One natural sub-module: `result_regfile`, an `N_POS*N_CH` x `DW` register array with a dual write port (byte pair per position) and an asynchronous read port.
- The FSM and pointers stay in `feature_map_readout`.

## Test plan
- Fill and full drain: reset, then 36 `in_valid` pulses with `in_data_0 = 2p`, `in_data_1 = 2p+1`, with `out_ready = 1`. Expect `out_data` 0,1,…,71 on consecutive cycles, `out_last` only on byte 71, `done = 1` one cycle later, `overflow = 0`.
- Backpressure: same fill, then drop `out_ready` for 5 cycles at index 10. Expect `out_data = 10` and `out_index = 10` held throughout, no skipped or duplicated bytes, and the stream resuming 11,12,….
- Overflow: during DRAIN at index 3, pulse `in_valid` with `0xAA`/`0xBB`. Expect `overflow = 1` from the next edge, streamed bytes still 0..71, and `0xAA` never appearing.
- Clear mid-collect: load 10 positions, assert `clear` together with `in_valid`, then load 36 positions with `in_data_0 = 0x80+p`, `in_data_1 = 0xC0+p`. Expect the stream to start `0x80, 0xC0, 0x81, 0xC1…` and `overflow = 0`.
- Async reset mid-drain: pull `rst_n` low between clock edges at index 40. Expect `out_valid`, `done` and `overflow` at 0 immediately; after release the state is COLLECT and an empty drain is never presented.
- Re-arm after DONE: from DONE, `in_valid` sets `overflow`. Then `clear` followed by a new fill streams the new data and `done` re-asserts after byte 71.
